// File: rtl/regfile_general_host_slave.sv
// regfile_general_host_slave: GENERAL register group host slave on a 4-phase req/ack bus.
// Define GEN_REGS_SHADOW_EN to stage config writes until a start command is issued.
module regfile_general_host_slave #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int NUM_CFG = 12,
    parameter int NUM_CMD = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    output logic                  host_ack,
    output logic [DATA_W-1:0]     host_rdata,
    output logic                  host_err,
    output logic [NUM_CFG*16-1:0] cfg_flat,
    input  logic [15:0]           status_in,
    input  logic                  buffer_loaded_evt,
    input  logic                  buffer_saved_evt,
    output logic                  buffer_loaded,
    output logic                  buffer_saved,
    output logic [NUM_CMD-1:0]    cmd_wr,
    output logic [NUM_CMD-1:0]    cmd_wr_en
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(16'h0040);
    localparam logic [ADDR_W-1:0] A_FLAGS  = ADDR_W'(16'h0041);
    localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(16'h0080);

    state_t                state_q, state_d;
    logic                  wr_q, wr_d, ack_q, ack_d, err_q, err_d;
    logic                  loaded_q, loaded_d, saved_q, saved_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d, cfg_rdata;
    logic [NUM_CMD-1:0]    cmd_q, cmd_d, cmd_en_q, cmd_en_d;
    logic [NUM_CFG*16-1:0] cfg_q, cfg_d, regs_rd, regs_wr;
    logic                  cfg_hit, wr_acc, flag_clr;

`ifdef GEN_REGS_SHADOW_EN
    logic [NUM_CFG*16-1:0] stage_q;
    assign regs_rd = stage_q;
    assign cfg_d   = (cmd_en_q[0] && cmd_q[0]) ? stage_q : cfg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= regs_wr;
    end
`else
    assign regs_rd = cfg_q;
    assign cfg_d   = regs_wr;
`endif

    assign wr_acc   = (state_q == ACCESS) && wr_q;
    assign flag_clr = wr_acc && (addr_q == A_FLAGS);
    assign loaded_d = buffer_loaded_evt | (loaded_q & ~(flag_clr & wdata_q[0]));
    assign saved_d  = buffer_saved_evt | (saved_q & ~(flag_clr & wdata_q[1]));

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_d     = ack_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cmd_d     = '0;
        cmd_en_d  = '0;
        regs_wr   = regs_rd;
        cfg_hit   = 1'b0;
        cfg_rdata = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (addr_q == ADDR_W'(i + 1)) begin
                cfg_hit   = 1'b1;
                cfg_rdata = regs_rd[i*16 +: 16];
                if (wr_acc) regs_wr[i*16 +: 16] = wdata_q;
            end
        end
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d = ACCESS;
                    wr_d    = host_wr;
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
                end
            end
            ACCESS: begin
                state_d = ACK;
                ack_d   = 1'b1;
                err_d   = 1'b0;
                rdata_d = '0;
                if (cfg_hit) rdata_d = wr_q ? '0 : cfg_rdata;
                else if (addr_q == A_STATUS) begin
                    err_d   = wr_q;
                    rdata_d = wr_q ? '0 : status_in;
                end
                else if (addr_q == A_FLAGS) rdata_d = wr_q ? '0 : DATA_W'({saved_q, loaded_q});
                else if (addr_q == A_CMD) begin
                    cmd_en_d = wr_q ? '1 : '0;
                    cmd_d    = wr_q ? wdata_q[NUM_CMD-1:0] : '0;
                end
                else err_d = 1'b1;
            end
            ACK: begin
                if (!host_req) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            loaded_q <= 1'b0;
            saved_q  <= 1'b0;
            cmd_q    <= '0;
            cmd_en_q <= '0;
            cfg_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            loaded_q <= loaded_d;
            saved_q  <= saved_d;
            cmd_q    <= cmd_d;
            cmd_en_q <= cmd_en_d;
            cfg_q    <= cfg_d;
        end
    end

    assign host_ack      = ack_q;
    assign host_err      = err_q;
    assign host_rdata    = rdata_q;
    assign buffer_loaded = loaded_q;
    assign buffer_saved  = saved_q;
    assign cmd_wr        = cmd_q;
    assign cmd_wr_en     = cmd_en_q;
    assign cfg_flat      = cfg_q;
endmodule

// File: tb/tb_regfile_general_host_slave.sv
// tb_regfile_general_host_slave: directed tests of the GENERAL register host slave.
module tb_regfile_general_host_slave;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         host_req = 1'b0, host_wr = 1'b0;
    logic [15:0]  host_addr = '0, host_wdata = '0;
    logic         host_ack, host_err;
    logic [15:0]  host_rdata;
    logic [191:0] cfg_flat;
    logic [15:0]  status_in = '0;
    logic         buffer_loaded_evt = 1'b0, buffer_saved_evt = 1'b0;
    logic         buffer_loaded, buffer_saved;
    logic [9:0]   cmd_wr, cmd_wr_en;

    int           n_cmp = 0, n_fail = 0;
    int           r_lat, r_held, hold_cycles = 0;
    logic         evt_in_access = 1'b0;
    logic [15:0]  r_rdata, r_rd_after;
    logic         r_err, r_ack_after;
    logic [9:0]   r_en0, r_cmd0, r_en1, r_cmd1;
    logic [191:0] saved_cfg;

    regfile_general_host_slave dut (
        .clk(clk), .rst_n(rst_n), .host_req(host_req), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .host_err(host_err), .cfg_flat(cfg_flat),
        .status_in(status_in), .buffer_loaded_evt(buffer_loaded_evt),
        .buffer_saved_evt(buffer_saved_evt), .buffer_loaded(buffer_loaded),
        .buffer_saved(buffer_saved), .cmd_wr(cmd_wr), .cmd_wr_en(cmd_wr_en)
    );

    always #5 clk = ~clk;

    // One full 4-phase access; bus inputs are scrambled after latching to prove they are ignored.
    task automatic bus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        @(negedge clk);
        host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wdata;
        @(posedge clk); #1;
        host_wr = ~wr; host_addr = 16'h0099; host_wdata = 16'h5555;
        if (evt_in_access) buffer_saved_evt = 1'b1;
        n = 1;
        while (!host_ack && n < 10) begin
            @(posedge clk); #1;
            buffer_saved_evt = 1'b0;
            n++;
        end
        r_lat = host_ack ? n : -1;
        r_rdata = host_rdata; r_err = host_err; r_en0 = cmd_wr_en; r_cmd0 = cmd_wr;
        r_held = 0;
        repeat (hold_cycles) begin
            @(posedge clk); #1;
            if (host_ack && host_rdata == r_rdata) r_held++;
        end
        @(negedge clk);
        host_req = 1'b0;
        @(posedge clk); #1;
        r_ack_after = host_ack; r_rd_after = host_rdata; r_en1 = cmd_wr_en; r_cmd1 = cmd_wr;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if ({host_ack, host_err, host_rdata, cmd_wr_en, cmd_wr, buffer_loaded, buffer_saved} !== '0) begin n_fail++; $display("FAIL reset_outputs got ack=%b err=%b rd=%h en=%h cmd=%h", host_ack, host_err, host_rdata, cmd_wr_en, cmd_wr); end
        n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("FAIL reset_cfg got %h want 0", cfg_flat); end
        @(negedge clk); rst_n = 1'b1;
        bus(1'b0, 16'h0005, 16'h0);
        n_cmp++; if (r_lat !== 2) begin n_fail++; $display("FAIL read_latency got %0d want 2", r_lat); end
        n_cmp++; if ({r_err, r_rdata} !== 17'h0) begin n_fail++; $display("FAIL read5 got err=%b rd=%h want 0/0000", r_err, r_rdata); end
        n_cmp++; if ({r_ack_after, r_rd_after} !== 17'h0) begin n_fail++; $display("FAIL ack_drop got ack=%b rd=%h want 0/0000", r_ack_after, r_rd_after); end
        n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("FAIL cfg_after_read got %h want 0", cfg_flat); end
    endtask

    task automatic test_cfg;
        bus(1'b1, 16'h0001, 16'hABC3);
        n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL cfg_write_err got %b want 0", r_err); end
        bus(1'b1, 16'h000C, 16'h1234);
`ifdef GEN_REGS_SHADOW_EN
        n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("FAIL shadow_hold got %h want 0", cfg_flat); end
        bus(1'b1, 16'h0080, 16'h0001);
`endif
        n_cmp++; if (cfg_flat[15:0] !== 16'hABC3) begin n_fail++; $display("FAIL cfg1_flat got %h want abc3", cfg_flat[15:0]); end
        n_cmp++; if ({cfg_flat[15:4], cfg_flat[3:0]} !== {12'hABC, 4'h3}) begin n_fail++; $display("FAIL cfg1_fields got %h/%h want abc/3", cfg_flat[15:4], cfg_flat[3:0]); end
        n_cmp++; if (cfg_flat[191:176] !== 16'h1234) begin n_fail++; $display("FAIL cfg12_flat got %h want 1234", cfg_flat[191:176]); end
        n_cmp++; if (cfg_flat[175:16] !== '0) begin n_fail++; $display("FAIL cfg_middle got %h want 0", cfg_flat[175:16]); end
        bus(1'b0, 16'h0001, 16'h0);
        n_cmp++; if ({r_err, r_rdata} !== {1'b0, 16'hABC3}) begin n_fail++; $display("FAIL cfg1_read got err=%b rd=%h want 0/abc3", r_err, r_rdata); end
        bus(1'b0, 16'h000C, 16'h0);
        n_cmp++; if ({r_err, r_rdata} !== {1'b0, 16'h1234}) begin n_fail++; $display("FAIL cfg12_read got err=%b rd=%h want 0/1234", r_err, r_rdata); end
        bus(1'b0, 16'h000D, 16'h0);
        n_cmp++; if ({r_err, r_rdata} !== {1'b1, 16'h0}) begin n_fail++; $display("FAIL addr_d_read got err=%b rd=%h want 1/0000", r_err, r_rdata); end
        bus(1'b1, 16'h0000, 16'hFFFF);
        n_cmp++; if (r_err !== 1'b1 || cfg_flat[15:0] !== 16'hABC3) begin n_fail++; $display("FAIL addr0_write got err=%b cfg1=%h want 1/abc3", r_err, cfg_flat[15:0]); end
    endtask

    task automatic test_cmd;
        bus(1'b1, 16'h0080, 16'hFE01);
        n_cmp++; if ({r_en0, r_cmd0} !== {10'h3FF, 10'h201}) begin n_fail++; $display("FAIL cmd_pulse got en=%h cmd=%h want 3ff/201", r_en0, r_cmd0); end
        n_cmp++; if ({r_en1, r_cmd1} !== 20'h0) begin n_fail++; $display("FAIL cmd_clear got en=%h cmd=%h want 0/0", r_en1, r_cmd1); end
        n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL cmd_err got %b want 0", r_err); end
        bus(1'b0, 16'h0080, 16'h0);
        n_cmp++; if ({r_err, r_rdata, r_en0} !== 27'h0) begin n_fail++; $display("FAIL cmd_read got err=%b rd=%h en=%h want 0/0/0", r_err, r_rdata, r_en0); end
    endtask

    task automatic test_sticky;
        @(negedge clk); buffer_saved_evt = 1'b1;
        @(negedge clk); buffer_saved_evt = 1'b0;
        n_cmp++; if ({buffer_saved, buffer_loaded} !== 2'b10) begin n_fail++; $display("FAIL saved_set got %b%b want 10", buffer_saved, buffer_loaded); end
        bus(1'b0, 16'h0041, 16'h0);
        n_cmp++; if (r_rdata !== 16'h0002) begin n_fail++; $display("FAIL flags_read got %h want 0002", r_rdata); end
        evt_in_access = 1'b1;
        bus(1'b1, 16'h0041, 16'h0002);
        evt_in_access = 1'b0;
        n_cmp++; if (buffer_saved !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b want 1", buffer_saved); end
        bus(1'b1, 16'h0041, 16'h0002);
        n_cmp++; if (buffer_saved !== 1'b0) begin n_fail++; $display("FAIL w1c_saved got %b want 0", buffer_saved); end
        @(negedge clk); buffer_loaded_evt = 1'b1;
        @(negedge clk); buffer_loaded_evt = 1'b0;
        bus(1'b1, 16'h0041, 16'h0002);
        bus(1'b0, 16'h0041, 16'h0);
        n_cmp++; if (r_rdata !== 16'h0001) begin n_fail++; $display("FAIL loaded_kept got %h want 0001", r_rdata); end
        bus(1'b1, 16'h0041, 16'h0001);
        n_cmp++; if ({buffer_saved, buffer_loaded} !== 2'b00) begin n_fail++; $display("FAIL w1c_loaded got %b%b want 00", buffer_saved, buffer_loaded); end
    endtask

    task automatic test_errors;
        bus(1'b0, 16'h0099, 16'h0);
        n_cmp++; if ({r_err, r_rdata} !== {1'b1, 16'h0}) begin n_fail++; $display("FAIL unmapped_read got err=%b rd=%h want 1/0000", r_err, r_rdata); end
        saved_cfg = cfg_flat;
        bus(1'b1, 16'h0040, 16'hFFFF);
        n_cmp++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL status_write_err got %b want 1", r_err); end
        n_cmp++; if (cfg_flat !== saved_cfg || {buffer_saved, buffer_loaded, cmd_wr_en} !== 12'h0) begin n_fail++; $display("FAIL status_write_side got cfg=%h flags=%b%b", cfg_flat, buffer_saved, buffer_loaded); end
        status_in = 16'h5A5A;
        bus(1'b0, 16'h0040, 16'h0);
        n_cmp++; if ({r_err, r_rdata} !== {1'b0, 16'h5A5A}) begin n_fail++; $display("FAIL status_read got err=%b rd=%h want 0/5a5a", r_err, r_rdata); end
    endtask

    task automatic test_hold;
        hold_cycles = 5;
        bus(1'b0, 16'h0001, 16'h0);
        hold_cycles = 0;
        n_cmp++; if (r_held !== 5) begin n_fail++; $display("FAIL ack_hold got %0d cycles want 5", r_held); end
        n_cmp++; if (r_ack_after !== 1'b0) begin n_fail++; $display("FAIL hold_release got ack=%b want 0", r_ack_after); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0001;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack got %b want 1", host_ack); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({host_ack, host_rdata} !== 17'h0) begin n_fail++; $display("FAIL async_reset got ack=%b rd=%h want 0/0000", host_ack, host_rdata); end
        @(negedge clk); host_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b1; host_addr = 16'h0002; host_wdata = 16'h7777;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 host_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus(1'b0, 16'h0002, 16'h0);
        n_cmp++; if ({r_lat, r_err, r_rdata} !== {32'd2, 1'b0, 16'h0}) begin n_fail++; $display("FAIL partial_write got lat=%0d err=%b rd=%h want 2/0/0000", r_lat, r_err, r_rdata); end
        n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("FAIL cfg_after_reset got %h want 0", cfg_flat); end
    endtask

    initial begin
        test_reset;
        test_cfg;
        test_cmd;
        test_sticky;
        test_errors;
        test_hold;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_general_host_slave.md
Name: regfile_general_host_slave

Overview:
- Host-facing writer for the GENERAL register group of the accelerator register interface.
- Decodes a 4-phase req/ack host bus. Holds configuration registers REG_0001..REG_000C.
- Returns REG_0040 status and the REG_0041 sticky buffer flags.
- Turns writes to REG_0080 into one-cycle command strobes consumed by the control/datapath side.

Parameters:
- ADDR_W, 16, host address width
- DATA_W, 16, host data and register width (fixed at 16; other values unsupported)
- NUM_CFG, 12, number of config registers (addresses 0x0001..0x000C)
- NUM_CMD, 10, number of command bits in REG_0080

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  host request, 4-phase
- host_wr  in  1  1=write, 0=read; valid while host_req=1
- host_addr  in  ADDR_W  register address
- host_wdata  in  DATA_W  write data
- host_ack  out  1  access complete
- host_rdata  out  DATA_W  read data, valid while host_ack=1
- host_err  out  1  unmapped or illegal access, valid while host_ack=1
- cfg_flat  out  NUM_CFG*16  config registers; 0x0001 at [15:0], 0x000C at [191:176]; 0x0001 bits [3:0]=store_to, [15:4]=layer_type
- status_in  in  16  REG_0040 live value from datapath
- buffer_loaded_evt  in  1  one-cycle pulse, buffer load done
- buffer_saved_evt  in  1  one-cycle pulse, buffer save done
- buffer_loaded  out  1  sticky flag (REG_0041 bit 0)
- buffer_saved  out  1  sticky flag (REG_0041 bit 1)
- cmd_wr  out  NUM_CMD  command values; bit order start, abrupt_end, reset, digital_reset, flush_buff1, flush_buff2, load_buff1, load_buff2, start_loading_buffer, start_saving_buffer
- cmd_wr_en  out  NUM_CMD  command strobes

Behaviour:
- clk is the single clock. rst_n is asynchronous, active-low. Every flop clears immediately on rst_n=0.
- Reset values: all outputs 0, FSM in IDLE, cfg_flat all 0.
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE: when host_req=1 at a clock edge, latch host_wr, host_addr and host_wdata, then go to ACCESS.
- ACCESS (one cycle): perform the access and register host_rdata and host_err. Set host_ack=1 on the transition to ACK. Latency is 2 edges from req sampled to ack high.
- ACK: hold host_ack, host_rdata and host_err stable while host_req=1. On the first edge with host_req=0, clear host_ack, host_rdata and host_err to 0 and go to IDLE.
- A new request is accepted no earlier than the edge after IDLE is entered.
- Write 0x0001..0x000C: store the full 16 bits. Read returns the stored value.
- Read 0x0040: returns status_in sampled in ACCESS.
- Write 0x0040: host_err=1, no effect.
- Read 0x0041: returns {14'b0, buffer_saved, buffer_loaded}.
- Write 0x0041 is write-1-to-clear: wdata[0] clears buffer_loaded, wdata[1] clears buffer_saved.
- Sticky flags: an evt pulse sets the flag on the next edge. If set and clear happen in the same cycle, set wins.
- Write 0x0080: in the cycle after ACCESS, all cmd_wr_en bits are 1 for exactly one cycle and cmd_wr=wdata[9:0]. Otherwise both cmd_wr and cmd_wr_en are 0. wdata[15:10] is ignored.
- Read 0x0080 returns 0 (write-only, no error).
- Any other address: host_err=1, host_rdata=0, no side effects.
- Changes to host_addr, host_wr or host_wdata after latching are ignored.
- Reset asserted mid-transaction drops host_ack immediately. No partial write survives.

Optional Feature:
- Macro GEN_REGS_SHADOW_EN.
- When defined: host writes go to an internal staging copy. cfg_flat updates from staging only in the cycle where cmd_wr_en[0]=1 and cmd_wr[0]=1 (start). Reads of 0x0001..0x000C return the staging value.
- When not defined: cfg_flat reflects writes on the edge ending ACCESS, with no staging registers.

Test Plan:
- Reset, then read 0x0005 -> host_ack after 2 edges, host_rdata=0x0000, host_err=0, cfg_flat=0.
- Write 0x0001=0xABC3, then read it back -> rdata=0xABC3, cfg_flat[3:0]=0x3, cfg_flat[15:4]=0xABC. With shadow: cfg_flat unchanged until write 0x0080=0x0001.
- Write 0x0080=0x0201 -> exactly one cycle of cmd_wr_en=0x3FF, cmd_wr=0x201, then both 0.
- Pulse buffer_saved_evt; read 0x0041 -> 0x0002. Write 0x0041=0x0002 in the same cycle as a buffer_saved_evt -> flag stays 1. Repeat without the event -> flag 0.
- Read 0x0099 -> host_err=1, rdata=0. Write 0x0040=0xFFFF -> host_err=1, no state change.
- Hold host_req=1 for 5 cycles after ack -> ack held 5 cycles. Assert rst_n=0 while in ACK -> ack=0 immediately, FSM returns to IDLE.
